// File: rtl/fp_pkg.sv
// Shared definitions for the FP normalise/round datapath.
package fp_pkg;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RUP = 2'b10,
    RDN = 2'b11
  } rnd_mode_e;

  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_INX  = 1;
  localparam int FLG_ZERO = 0;

  localparam int GRS_W = 3;

endpackage

// File: rtl/fp_normalize_round_pipe_if.sv
// Upstream/downstream handshake bundle of the normalise/round pipe.
// slave: view of the pipe itself; master: view of the surrounding datapath.
interface fp_normalize_round_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();
  import fp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W+1:0] in_man;
  logic [GRS_W-1:0] in_grs;
  rnd_mode_e        rnd_mode;

  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_man;
  logic [3:0]       out_flags;

  modport slave (
    input  in_valid, in_sign, in_exp, in_man, in_grs, rnd_mode, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_man, out_flags
  );

  modport master (
    output in_valid, in_sign, in_exp, in_man, in_grs, rnd_mode, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_man, out_flags
  );

endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; o_count = W and o_zero = 1 for an all-zero input.
module fp_lzc #(
  parameter int W = 25
) (
  input  logic [W-1:0]           i_data,
  output logic [$clog2(W+1)-1:0] o_count,
  output logic                   o_zero
);

  // Scan upward so the most significant set bit determines the count.
  always_comb begin
    o_count = ($clog2(W+1))'(W);
    o_zero  = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      if (i_data[i]) begin
        o_count = ($clog2(W+1))'(W - 1 - i);
        o_zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_normalize_round_pipe.sv
// Two-stage normalise (stage 1) and round (stage 2) pipe with valid/ready.
// Optional macro FPNORM_SUBNORMAL_EN: keep subnormal results instead of flushing to zero.
module fp_normalize_round_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic                     clk,
  input logic                     reset,
  fp_normalize_round_pipe_if.slave bus
);

  localparam int LZ_W = $clog2(MAN_W + 3);
  localparam int SE_W = EXP_W + 2;
  localparam int V_W  = MAN_W + 3;
  localparam logic [EXP_W:0]   EXP_INF = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] EXP_MXF = {{(EXP_W-1){1'b1}}, 1'b0};

  logic             r1_valid, r1_sign, r1_zero, r1_flush, r1_g, r1_r, r1_s;
  logic [EXP_W:0]   r1_exp;
  logic [MAN_W:0]   r1_man;
  rnd_mode_e        r1_rnd;

  logic             r2_valid, r2_sign;
  logic [EXP_W-1:0] r2_exp;
  logic [MAN_W-1:0] r2_man;
  logic [3:0]       r2_flags;

  logic w_s2_ready, w_in_ready;
  assign w_s2_ready   = !r2_valid || bus.out_ready;
  assign w_in_ready   = !r1_valid || w_s2_ready;
  assign bus.in_ready = w_in_ready;

  logic [LZ_W-1:0] w_lz;
  logic            w_lz_zero;

  fp_lzc #(.W(MAN_W + 2)) u_lzc (
    .i_data  ({bus.in_man[MAN_W:0], bus.in_grs[2]}),
    .o_count (w_lz),
    .o_zero  (w_lz_zero)
  );

  logic                   w_carry, w_zero, w_short;
  logic signed [SE_W-1:0] w_exp_l;
  logic [SE_W-1:0]        w_sh;
  logic [V_W-1:0]         w_v;
  logic [EXP_W:0]         w_n_exp;
  logic [MAN_W:0]         w_n_man;
  logic                   w_n_g, w_n_r, w_n_s;

  // Stage 1: right-normalise on carry, otherwise left-normalise by the leading-zero count.
  // Guard and round travel with the fraction as one vector so they shift in behind it.
  always_comb begin
    w_carry = bus.in_man[MAN_W+1];
    w_zero  = (bus.in_man == '0) && (bus.in_grs == '0);
    w_exp_l = $signed({2'b00, bus.in_exp}) - $signed(SE_W'(w_lz));
    // Too small to normalise: exponent would drop below 1, or only sticky is left.
    w_short = w_exp_l[SE_W-1] || (w_exp_l == '0) || (w_lz_zero && !bus.in_grs[1]);
`ifdef FPNORM_SUBNORMAL_EN
    w_sh = w_short ? (SE_W'(bus.in_exp) - SE_W'(1)) : SE_W'(w_lz);
`else
    w_sh = SE_W'(w_lz);
`endif
    w_v = {bus.in_man[MAN_W:0], bus.in_grs[2:1]} << w_sh;
    if (w_carry) begin
      w_n_man = bus.in_man[MAN_W+1:1];
      w_n_g   = bus.in_man[0];
      w_n_r   = bus.in_grs[2];
      w_n_s   = |bus.in_grs[1:0];
      w_n_exp = {1'b0, bus.in_exp} + (EXP_W+1)'(1);
    end else begin
      w_n_man = w_v[V_W-1:2];
      w_n_g   = w_v[1];
      w_n_r   = w_v[0];
      w_n_s   = bus.in_grs[0];
      w_n_exp = w_short ? '0 : w_exp_l[EXP_W:0];
    end
  end

  // Stage 1 register: loads whenever the stage is empty or stage 2 takes its beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_zero  <= 1'b0;
      r1_flush <= 1'b0;
      r1_g     <= 1'b0;
      r1_r     <= 1'b0;
      r1_s     <= 1'b0;
      r1_exp   <= '0;
      r1_man   <= '0;
      r1_rnd   <= RNE;
    end else if (w_in_ready) begin
      r1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r1_sign  <= bus.in_sign;
        r1_zero  <= w_zero;
`ifdef FPNORM_SUBNORMAL_EN
        r1_flush <= 1'b0;
`else
        r1_flush <= !w_carry && w_short;
`endif
        r1_g     <= w_n_g;
        r1_r     <= w_n_r;
        r1_s     <= w_n_s;
        r1_exp   <= w_n_exp;
        r1_man   <= w_n_man;
        r1_rnd   <= bus.rnd_mode;
      end
    end
  end

  logic             w_inc, w_inx, w_ovf, w_to_inf;
  logic [MAN_W+1:0] w_sum;
  logic [EXP_W:0]   w_r_exp;
  logic             w_o_sign;
  logic [EXP_W-1:0] w_o_exp;
  logic [MAN_W-1:0] w_o_man;
  logic [3:0]       w_o_flags;

  // Stage 2: round, then resolve zero / flush / overflow special results.
  always_comb begin
    w_inx = r1_g | r1_r | r1_s;
    case (r1_rnd)
      RNE:     w_inc = r1_g & (r1_r | r1_s | r1_man[0]);
      RUP:     w_inc = !r1_sign & w_inx;
      RDN:     w_inc = r1_sign & w_inx;
      default: w_inc = 1'b0;
    endcase
    w_sum = {1'b0, r1_man} + (MAN_W+2)'(w_inc);
    // A subnormal rounding up into the hidden bit becomes the smallest normal.
    if ((r1_exp == '0) && w_sum[MAN_W]) w_r_exp = (EXP_W+1)'(1);
    else                                w_r_exp = r1_exp + (EXP_W+1)'(w_sum[MAN_W+1]);
    w_ovf    = w_r_exp >= EXP_INF;
    w_to_inf = (r1_rnd == RNE) || ((r1_rnd == RUP) && !r1_sign) || ((r1_rnd == RDN) && r1_sign);

    w_o_sign  = r1_sign;
    w_o_exp   = w_r_exp[EXP_W-1:0];
    w_o_man   = w_sum[MAN_W+1] ? '0 : w_sum[MAN_W-1:0];
    w_o_flags = '0;
    w_o_flags[FLG_INX] = w_inx;

    if (r1_zero) begin
      w_o_sign  = (r1_rnd == RDN);
      w_o_exp   = '0;
      w_o_man   = '0;
      w_o_flags = '0;
      w_o_flags[FLG_ZERO] = 1'b1;
    end else if (r1_flush) begin
      w_o_exp   = '0;
      w_o_man   = '0;
      w_o_flags[FLG_UNF]  = 1'b1;
      w_o_flags[FLG_INX]  = 1'b1;
      w_o_flags[FLG_ZERO] = 1'b1;
    end else if (w_ovf) begin
      w_o_exp = w_to_inf ? '1 : EXP_MXF;
      w_o_man = w_to_inf ? '0 : '1;
      w_o_flags[FLG_OVF] = 1'b1;
      w_o_flags[FLG_INX] = 1'b1;
    end else begin
`ifdef FPNORM_SUBNORMAL_EN
      w_o_flags[FLG_UNF]  = (w_r_exp == '0) && w_inx;
      w_o_flags[FLG_ZERO] = (w_r_exp == '0) && (w_o_man == '0);
`endif
    end
  end

  // Stage 2 / output register: holds while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_exp   <= '0;
      r2_man   <= '0;
      r2_flags <= '0;
    end else if (w_s2_ready) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sign  <= w_o_sign;
        r2_exp   <= w_o_exp;
        r2_man   <= w_o_man;
        r2_flags <= w_o_flags;
      end
    end
  end

  assign bus.out_valid = r2_valid;
  assign bus.out_sign  = r2_sign;
  assign bus.out_exp   = r2_exp;
  assign bus.out_man   = r2_man;
  assign bus.out_flags = r2_flags;

endmodule
